// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control FSM for a shared-resource multicycle MIPS datapath. A single memory
// serves instruction fetch and data access, and a single ALU handles the PC
// increment, the branch target and the execute step.
// Optional feature: define MULTICYCLE_PERF_CNT_EN to build the cycle and
// retired-instruction performance counters. When it is undefined, cycle_cnt
// and instr_cnt are tied to zero.
module multicycle_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  operation,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        instr_we,
  output logic        i_or_d,
  output logic        mem_re,
  output logic        mem_we,
  output logic        reg_we,
  output logic        reg_write_addr,
  output logic        reg_write_data,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_controller,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLL  = 3'b011;
  localparam logic [2:0] ALU_SRL  = 3'b100;
  localparam logic [2:0] ALU_SRA  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB_R  = 4'd8,
    ALU_WB_I  = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    JR        = 4'd12,
    TRAP      = 4'd13
  } state_t;

  // Legal R-type funct codes that go through EXEC_R (jr is handled separately).
  function automatic logic is_exec_rfunc(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
      6'b000100, 6'b000110, 6'b000111,
      6'b000000, 6'b000010, 6'b000011: is_exec_rfunc = 1'b1;
      default:                         is_exec_rfunc = 1'b0;
    endcase
  endfunction

  // ALU operation for an R-type funct; variable shifts share the shift ops.
  function automatic logic [2:0] rfunc_alu(input logic [5:0] f);
    case (f)
      6'b100000:            rfunc_alu = ALU_ADD;
      6'b100010:            rfunc_alu = ALU_SUB;
      6'b100100:            rfunc_alu = ALU_AND;
      6'b100101:            rfunc_alu = ALU_OR;
      6'b101010:            rfunc_alu = ALU_SLT;
      6'b000100, 6'b000000: rfunc_alu = ALU_SLL;
      6'b000110, 6'b000010: rfunc_alu = ALU_SRL;
      6'b000111, 6'b000011: rfunc_alu = ALU_SRA;
      default:              rfunc_alu = ALU_ADD;
    endcase
  endfunction

  // Constant-shift functs take their shift amount from the shamt field.
  function automatic logic is_shamt_func(input logic [5:0] f);
    is_shamt_func = (f == 6'b000000) || (f == 6'b000010) || (f == 6'b000011);
  endfunction

  state_t      state_r;
  state_t      next_state_s;
  logic        illegal_r;

  logic        pc_we_s;
  logic        instr_we_s;
  logic        i_or_d_s;
  logic        mem_re_s;
  logic        mem_we_s;
  logic        reg_we_s;
  logic        reg_write_addr_s;
  logic        reg_write_data_s;
  logic [1:0]  alu_src_a_s;
  logic [1:0]  alu_src_b_s;
  logic [1:0]  pc_src_s;
  logic [2:0]  alu_controller_s;

  // State register; reset returns to FETCH and abandons any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Sticky illegal flag, set on entry to TRAP and cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else if (next_state_s == TRAP) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  // Next-state decode and per-state datapath controls.
  always_comb begin
    next_state_s     = state_r;
    pc_we_s          = 1'b0;
    instr_we_s       = 1'b0;
    i_or_d_s         = 1'b0;
    mem_re_s         = 1'b0;
    mem_we_s         = 1'b0;
    reg_we_s         = 1'b0;
    reg_write_addr_s = 1'b0;
    reg_write_data_s = 1'b0;
    alu_src_a_s      = 2'b00;
    alu_src_b_s      = 2'b00;
    pc_src_s         = 2'b00;
    alu_controller_s = 3'b000;
    case (state_r)
      FETCH: begin
        mem_re_s         = 1'b1;
        alu_src_b_s      = 2'b01;
        alu_controller_s = ALU_ADD;
        if (mem_ready) begin
          pc_we_s      = 1'b1;
          instr_we_s   = 1'b1;
          next_state_s = DECODE;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
        alu_src_b_s      = 2'b11;
        alu_controller_s = ALU_ADD;
        case (operation)
          OP_LW, OP_SW:              next_state_s = MEM_ADDR;
          OP_RTYPE: begin
            if (func == FN_JR) begin
              next_state_s = JR;
            end else if (is_exec_rfunc(func)) begin
              next_state_s = EXEC_R;
            end else begin
              next_state_s = TRAP;
            end
          end
          OP_ADDI, OP_ANDI, OP_ORI:  next_state_s = EXEC_I;
          OP_BEQ, OP_BNE:            next_state_s = BRANCH;
          OP_J:                      next_state_s = JUMP;
          default:                   next_state_s = TRAP;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a_s      = 2'b01;
        alu_src_b_s      = 2'b10;
        alu_controller_s = ALU_ADD;
        if (operation == OP_LW) begin
          next_state_s = MEM_READ;
        end else begin
          next_state_s = MEM_WRITE;
        end
      end
      MEM_READ: begin
        mem_re_s = 1'b1;
        i_or_d_s = 1'b1;
        if (mem_ready) begin
          next_state_s = MEM_WB;
        end else begin
          next_state_s = MEM_READ;
        end
      end
      MEM_WB: begin
        reg_we_s         = 1'b1;
        reg_write_data_s = 1'b1;
        next_state_s     = FETCH;
      end
      MEM_WRITE: begin
        mem_we_s = 1'b1;
        i_or_d_s = 1'b1;
        if (mem_ready) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = MEM_WRITE;
        end
      end
      EXEC_R: begin
        alu_src_a_s      = is_shamt_func(func) ? 2'b10 : 2'b01;
        alu_controller_s = rfunc_alu(func);
        next_state_s     = ALU_WB_R;
      end
      EXEC_I: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        case (operation)
          OP_ANDI: alu_controller_s = ALU_AND;
          OP_ORI:  alu_controller_s = ALU_OR;
          default: alu_controller_s = ALU_ADD;
        endcase
        next_state_s = ALU_WB_I;
      end
      ALU_WB_R: begin
        reg_we_s         = 1'b1;
        reg_write_addr_s = 1'b1;
        next_state_s     = FETCH;
      end
      ALU_WB_I: begin
        reg_we_s     = 1'b1;
        next_state_s = FETCH;
      end
      BRANCH: begin
        alu_src_a_s      = 2'b01;
        alu_controller_s = ALU_SUB;
        pc_src_s         = 2'b01;
        pc_we_s          = ((operation == OP_BEQ) && zero) ||
                           ((operation == OP_BNE) && !zero);
        next_state_s     = FETCH;
      end
      JUMP: begin
        pc_src_s     = 2'b10;
        pc_we_s      = 1'b1;
        next_state_s = FETCH;
      end
      JR: begin
        pc_src_s     = 2'b11;
        pc_we_s      = 1'b1;
        next_state_s = FETCH;
      end
      TRAP: begin
        next_state_s = TRAP;
      end
      default: begin
        next_state_s = TRAP;
      end
    endcase
  end

  // Enables are qualified by rst_n so nothing fires while reset is held.
  assign pc_we          = pc_we_s    & rst_n;
  assign instr_we       = instr_we_s & rst_n;
  assign mem_re         = mem_re_s   & rst_n;
  assign mem_we         = mem_we_s   & rst_n;
  assign reg_we         = reg_we_s   & rst_n;
  assign i_or_d         = i_or_d_s;
  assign reg_write_addr = reg_write_addr_s;
  assign reg_write_data = reg_write_data_s;
  assign alu_src_a      = alu_src_a_s;
  assign alu_src_b      = alu_src_b_s;
  assign pc_src         = pc_src_s;
  assign alu_controller = alu_controller_s;
  assign illegal        = illegal_r;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_cnt_r;
  logic [31:0] instr_cnt_r;
  logic        retire_s;

  assign retire_s = (next_state_s == FETCH) &&
                    ((state_r == MEM_WB)   || (state_r == MEM_WRITE) ||
                     (state_r == ALU_WB_R) || (state_r == ALU_WB_I)  ||
                     (state_r == BRANCH)   || (state_r == JUMP)      ||
                     (state_r == JR));

  // Performance counters: cycles outside TRAP and retired instructions, wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_r <= 32'd0;
      instr_cnt_r <= 32'd0;
    end else begin
      cycle_cnt_r <= (state_r != TRAP) ? cycle_cnt_r + 32'd1 : cycle_cnt_r;
      instr_cnt_r <= retire_s ? instr_cnt_r + 32'd1 : instr_cnt_r;
    end
  end

  assign cycle_cnt = cycle_cnt_r;
  assign instr_cnt = instr_cnt_r;
`else
  assign cycle_cnt = 32'd0;
  assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller. Control outputs are
// packed into one vector and compared against hand-derived per-state values.
module tb_multicycle_controller;

  logic        clk;
  logic        rst_n;
  logic [5:0]  operation;
  logic [5:0]  func;
  logic        zero;
  logic        mem_ready;
  logic        pc_we, instr_we, i_or_d, mem_re, mem_we, reg_we;
  logic        reg_write_addr, reg_write_data;
  logic [1:0]  alu_src_a, alu_src_b, pc_src;
  logic [2:0]  alu_controller;
  logic        illegal;
  logic [31:0] cycle_cnt, instr_cnt;

  int checks;
  int failures;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .operation(operation), .func(func),
    .zero(zero), .mem_ready(mem_ready), .pc_we(pc_we), .instr_we(instr_we),
    .i_or_d(i_or_d), .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we),
    .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_controller(alu_controller), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  // {pc_we,instr_we,i_or_d,mem_re,mem_we,reg_we,wr_addr,wr_data,a,b,pc_src,alu}
  logic [16:0] ctrl_s;
  assign ctrl_s = {pc_we, instr_we, i_or_d, mem_re, mem_we, reg_we,
                   reg_write_addr, reg_write_data, alu_src_a, alu_src_b,
                   pc_src, alu_controller};

  localparam logic [16:0] V_RST    = 17'b00000000_00_01_00_010;
  localparam logic [16:0] V_F_RDY  = 17'b11010000_00_01_00_010;
  localparam logic [16:0] V_F_IDLE = 17'b00010000_00_01_00_010;
  localparam logic [16:0] V_DEC    = 17'b00000000_00_11_00_010;
  localparam logic [16:0] V_MADDR  = 17'b00000000_01_10_00_010;
  localparam logic [16:0] V_MREAD  = 17'b00110000_00_00_00_000;
  localparam logic [16:0] V_MWB    = 17'b00000101_00_00_00_000;
  localparam logic [16:0] V_MWRITE = 17'b00101000_00_00_00_000;
  localparam logic [16:0] V_EX_SRA = 17'b00000000_10_00_00_101;
  localparam logic [16:0] V_EX_SLT = 17'b00000000_01_00_00_111;
  localparam logic [16:0] V_WB_R   = 17'b00000110_00_00_00_000;
  localparam logic [16:0] V_EX_ADD = 17'b00000000_01_10_00_010;
  localparam logic [16:0] V_EX_ORI = 17'b00000000_01_10_00_001;
  localparam logic [16:0] V_WB_I   = 17'b00000100_00_00_00_000;
  localparam logic [16:0] V_BR_T   = 17'b10000000_01_00_01_110;
  localparam logic [16:0] V_BR_N   = 17'b00000000_01_00_01_110;
  localparam logic [16:0] V_JMP    = 17'b10000000_00_00_10_000;
  localparam logic [16:0] V_JR     = 17'b10000000_00_00_11_000;
  localparam logic [16:0] V_TRAP   = 17'b00000000_00_00_00_000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset pulse that leaves the DUT idling in FETCH at posedge+1.
  task automatic pulse_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    operation = 6'b100011;
    func = 6'b000000;
    zero = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl_s !== V_RST || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold ctrl=%b illegal=%b expected ctrl=%b illegal=0", ctrl_s, illegal, V_RST);
    end
    checks++;
    if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_counters cycle=%0d instr=%0d expected 0 0", cycle_cnt, instr_cnt);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ctrl_s !== V_F_RDY) begin
      failures++;
      $display("FAIL reset_release ctrl=%b expected %b", ctrl_s, V_F_RDY);
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw(input logic stall);
    logic [16:0] ev[$];
    logic        rv[$];
    if (stall) begin
      ev = '{V_F_RDY, V_DEC, V_MADDR, V_MREAD, V_MREAD, V_MREAD, V_MREAD, V_MWB, V_F_IDLE};
      rv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    end else begin
      ev = '{V_F_RDY, V_DEC, V_MADDR, V_MREAD, V_MWB, V_F_IDLE};
      rv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    end
    operation = 6'b100011;
    for (int i = 0; i < ev.size(); i++) begin
      mem_ready = rv[i];
      @(negedge clk);
      checks++;
      if (ctrl_s !== ev[i] || illegal !== 1'b0) begin
        failures++;
        $display("FAIL lw stall=%0d cycle=%0d ctrl=%b illegal=%b expected ctrl=%b", stall, i, ctrl_s, illegal, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    logic [16:0] ev[$] = '{V_F_RDY, V_DEC, V_MADDR, V_MWRITE, V_MWRITE, V_F_IDLE};
    logic        rv[$] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    operation = 6'b101011;
    for (int i = 0; i < ev.size(); i++) begin
      mem_ready = rv[i];
      @(negedge clk);
      checks++;
      if (ctrl_s !== ev[i]) begin
        failures++;
        $display("FAIL sw cycle=%0d ctrl=%b expected %b", i, ctrl_s, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [5:0]  ops[4]   = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    logic        zs[4]    = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [16:0] brv[4]   = '{V_BR_T, V_BR_N, V_BR_N, V_BR_T};
    logic [16:0] ev[4];
    for (int k = 0; k < 4; k++) begin
      operation = ops[k];
      zero = zs[k];
      ev = '{V_F_RDY, V_DEC, brv[k], V_F_IDLE};
      for (int i = 0; i < 4; i++) begin
        mem_ready = (i < 3) ? 1'b1 : 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl_s !== ev[i]) begin
          failures++;
          $display("FAIL branch op=%b zero=%b cycle=%0d ctrl=%b expected %b", ops[k], zs[k], i, ctrl_s, ev[i]);
        end
        @(posedge clk); #1;
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_rtype();
    logic [5:0]  fs[3]  = '{6'b000011, 6'b101010, 6'b001000};
    logic [16:0] e2[3]  = '{V_EX_SRA, V_EX_SLT, V_JR};
    logic [16:0] e3[3]  = '{V_WB_R, V_WB_R, V_F_IDLE};
    logic [16:0] ev[5];
    int          n;
    operation = 6'b000000;
    for (int k = 0; k < 3; k++) begin
      func = fs[k];
      ev = '{V_F_RDY, V_DEC, e2[k], e3[k], V_F_IDLE};
      n = (k == 2) ? 4 : 5;
      for (int i = 0; i < n; i++) begin
        mem_ready = (i < n - 1) ? 1'b1 : 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl_s !== ev[i]) begin
          failures++;
          $display("FAIL rtype func=%b cycle=%0d ctrl=%b expected %b", fs[k], i, ctrl_s, ev[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_itype();
    logic [5:0]  os[2] = '{6'b001000, 6'b001101};
    logic [16:0] ex[2] = '{V_EX_ADD, V_EX_ORI};
    logic [16:0] ev[5];
    for (int k = 0; k < 2; k++) begin
      operation = os[k];
      ev = '{V_F_RDY, V_DEC, ex[k], V_WB_I, V_F_IDLE};
      for (int i = 0; i < 5; i++) begin
        mem_ready = (i < 4) ? 1'b1 : 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl_s !== ev[i]) begin
          failures++;
          $display("FAIL itype op=%b cycle=%0d ctrl=%b expected %b", os[k], i, ctrl_s, ev[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_trap();
    logic [5:0] os[2] = '{6'b111111, 6'b000000};
    logic [5:0] fs[2] = '{6'b000000, 6'b000001};
    for (int k = 0; k < 2; k++) begin
      operation = os[k];
      func = fs[k];
      for (int i = 0; i < 22; i++) begin
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (i == 0 && ctrl_s !== V_F_RDY) begin
          failures++;
          $display("FAIL trap_fetch case=%0d ctrl=%b expected %b", k, ctrl_s, V_F_RDY);
        end else if (i == 1 && (ctrl_s !== V_DEC || illegal !== 1'b0)) begin
          failures++;
          $display("FAIL trap_decode case=%0d ctrl=%b illegal=%b expected ctrl=%b illegal=0", k, ctrl_s, illegal, V_DEC);
        end else if (i >= 2 && (ctrl_s !== V_TRAP || illegal !== 1'b1)) begin
          failures++;
          $display("FAIL trap_hold case=%0d cycle=%0d ctrl=%b illegal=%b expected ctrl=%b illegal=1", k, i, ctrl_s, illegal, V_TRAP);
        end
        @(posedge clk); #1;
      end
      pulse_reset();
      @(negedge clk);
      checks++;
      if (illegal !== 1'b0 || ctrl_s !== V_F_IDLE) begin
        failures++;
        $display("FAIL trap_clear case=%0d illegal=%b ctrl=%b expected illegal=0 ctrl=%b", k, illegal, ctrl_s, V_F_IDLE);
      end
      @(posedge clk); #1;
    end
    func = 6'b000000;
  endtask

  task automatic test_perf();
    logic [5:0] os[2] = '{6'b100011, 6'b000010};
    int         lens[2] = '{5, 3};
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      operation = os[k];
      mem_ready = 1'b1;
      repeat (lens[k]) @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl_s !== V_F_IDLE) begin
      failures++;
      $display("FAIL perf_seq_end ctrl=%b expected %b", ctrl_s, V_F_IDLE);
    end
`ifdef MULTICYCLE_PERF_CNT_EN
    checks++;
    if (instr_cnt !== 32'd2 || cycle_cnt !== 32'd9) begin
      failures++;
      $display("FAIL perf_counts instr=%0d cycle=%0d expected instr=2 cycle=9", instr_cnt, cycle_cnt);
    end
`else
    checks++;
    if (instr_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
      failures++;
      $display("FAIL perf_tied instr=%0d cycle=%0d expected 0 0", instr_cnt, cycle_cnt);
    end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    operation = 6'b000000;
    func = 6'b000000;
    zero = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_lw(1'b0);
    test_lw(1'b1);
    test_sw();
    test_branch();
    test_rtype();
    test_itype();
    test_trap();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
